// File: rtl/arb2_32.sv
// Two-requester, 32-bit packet arbiter driving a registered valid/ready output bus.
// Define ARB2_32_LOCK_EN to hold the grant across multi-beat packets (LAST-delimited).
module arb2_32 (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ0,
    input  logic [31:0] IN0,
    input  logic        LAST0,
    input  logic        REQ1,
    input  logic [31:0] IN1,
    input  logic        LAST1,
    output logic        GNT0,
    output logic        GNT1,
    output logic [31:0] Y,
    output logic        Y_VALID,
    input  logic        Y_READY,
    output logic        S0
);

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                ptr_q, ptr_d;
    logic [DATA_W-1:0]   y_q, y_d;
    logic                y_valid_q, y_valid_d;

    state_e              eff_state_c;
    logic                eff_ptr_c;
    logic                ld_c;
    logic                sel_c;
    logic                gnt0_c;
    logic                gnt1_c;
    logic                last0_c;
    logic                last1_c;

`ifdef ARB2_32_LOCK_EN
    assign last0_c = LAST0;
    assign last1_c = LAST1;
`else
    // Without locking every beat closes its packet; LAST inputs are don't-care.
    logic unused_last;
    assign unused_last = LAST0 ^ LAST1;
    assign last0_c     = 1'b1;
    assign last1_c     = 1'b1;
`endif

    // Output register may load when empty or being drained this edge.
    assign ld_c = (!y_valid_q || Y_READY) && RST_N;

    // Selection; while reset is asserted behave as the reset state (IDLE, PTR=1).
    always_comb begin
        eff_state_c = RST_N ? state_q : IDLE;
        eff_ptr_c   = RST_N ? ptr_q   : 1'b1;
        sel_c       = 1'b0;
        case (eff_state_c)
            OWN0:    sel_c = 1'b0;
            OWN1:    sel_c = 1'b1;
            default: begin
                if (REQ0 && REQ1) begin
                    sel_c = !eff_ptr_c;
                end else begin
                    sel_c = REQ1;
                end
            end
        endcase
    end

    assign gnt0_c = ld_c && !sel_c && REQ0;
    assign gnt1_c = ld_c &&  sel_c && REQ1;

    assign GNT0    = gnt0_c;
    assign GNT1    = gnt1_c;
    assign S0      = sel_c;
    assign Y       = y_q;
    assign Y_VALID = y_valid_q;

    // Data path and packet-ownership next state.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        y_d       = y_q;
        y_valid_d = y_valid_q;

        if (ld_c) begin
            if (gnt0_c) begin
                y_d       = IN0;
                y_valid_d = 1'b1;
            end else if (gnt1_c) begin
                y_d       = IN1;
                y_valid_d = 1'b1;
            end else begin
                y_valid_d = 1'b0;
            end
        end

        if (gnt0_c) begin
            if (last0_c) begin
                state_d = IDLE;
                ptr_d   = 1'b0;
            end else begin
                state_d = OWN0;
            end
        end else if (gnt1_c) begin
            if (last1_c) begin
                state_d = IDLE;
                ptr_d   = 1'b1;
            end else begin
                state_d = OWN1;
            end
        end
    end

    // Synchronous reset drops any held beat and the packet lock.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b1;
            y_q       <= DATA_W'(0);
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

endmodule
